// File: rtl/cdb_arbiter_if.sv
// Common data bus: one registered broadcast of a completed result per cycle.
// The arbiter is the only master; the register file and reservation stations are slaves.
interface CDB_IF #(
    parameter int ADDR_W = 6,
    parameter int VAL_W  = 32
);
    logic              valid;
    logic [ADDR_W-1:0] register_addr;
    logic [VAL_W-1:0]  register_val;

    modport master (output valid, register_addr, register_val);
    modport slave  (input  valid, register_addr, register_val);
endinterface

// File: rtl/cdb_arbiter.sv
// CDB master: per-unit result queues, round-robin pick of one head per cycle,
// and a registered broadcast onto the CDB plus a completion strobe to the ROB.
module cdb_arbiter #(
    parameter int NUM_FU                 = 3,
    parameter int FIFO_DEPTH             = 2,
    parameter int PHYSICAL_REG_NUM_WIDTH = 6,
    parameter int REG_VAL_WIDTH          = 32,
    parameter int ROB_SIZE_WIDTH         = 5
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic                                     flush,
    input  logic [NUM_FU-1:0]                        fu_valid,
    output logic [NUM_FU-1:0]                        fu_ready,
    input  logic [NUM_FU*PHYSICAL_REG_NUM_WIDTH-1:0] fu_reg_addr,
    input  logic [NUM_FU*REG_VAL_WIDTH-1:0]          fu_reg_val,
    input  logic [NUM_FU-1:0]                        fu_reg_wb,
    input  logic [NUM_FU*ROB_SIZE_WIDTH-1:0]         fu_inst_tag,
    CDB_IF.master                                    CDB_if,
    output logic                                     cdb_complete,
    output logic [ROB_SIZE_WIDTH-1:0]                cdb_inst_tag
);
    localparam int AW = PHYSICAL_REG_NUM_WIDTH;
    localparam int VW = REG_VAL_WIDTH;
    localparam int TW = ROB_SIZE_WIDTH;
    localparam int EW = AW + VW + 1 + TW;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int IW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    logic [NUM_FU-1:0] req;
    logic [EW-1:0]     head [NUM_FU];
    logic              gnt_valid;
    logic [IW-1:0]     gnt_idx;
    logic [IW-1:0]     rr_ptr_q, rr_ptr_d;

    // Entry layout: {addr, val, wb, tag}
    for (genvar gi = 0; gi < NUM_FU; gi++) begin : g_fifo
        logic [EW-1:0] mem_q [FIFO_DEPTH];
        logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
        logic [CW-1:0] cnt_q, cnt_d;
        logic          push, pop;

        assign fu_ready[gi] = (cnt_q != CW'(FIFO_DEPTH));
        assign req[gi]      = (cnt_q != '0);
        assign push         = fu_valid[gi] & fu_ready[gi];
        assign pop          = gnt_valid & (gnt_idx == IW'(gi));
        assign head[gi]     = mem_q[rd_ptr_q];

        always_comb begin
            wr_ptr_d = wr_ptr_q;
            rd_ptr_d = rd_ptr_q;
            cnt_d    = cnt_q;
            if (flush) begin
                wr_ptr_d = '0;
                rd_ptr_d = '0;
                cnt_d    = '0;
            end else begin
                if (push) wr_ptr_d = wr_ptr_q + PW'(1);
                if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
                if (push && !pop)      cnt_d = cnt_q + CW'(1);
                else if (!push && pop) cnt_d = cnt_q - CW'(1);
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                cnt_q    <= '0;
            end else begin
                wr_ptr_q <= wr_ptr_d;
                rd_ptr_q <= rd_ptr_d;
                cnt_q    <= cnt_d;
            end
        end

        // Payload storage needs no reset: an entry is only read while counted.
        always_ff @(posedge clk) begin
            if (push && !flush) begin
                mem_q[wr_ptr_q] <= {fu_reg_addr[gi*AW +: AW], fu_reg_val[gi*VW +: VW],
                                    fu_reg_wb[gi], fu_inst_tag[gi*TW +: TW]};
            end
        end
    end

    function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_FU) s = s - NUM_FU;
        return IW'(s);
    endfunction

    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            if (!gnt_valid && req[wrap_idx(rr_ptr_q, k)]) begin
                gnt_valid = 1'b1;
                gnt_idx   = wrap_idx(rr_ptr_q, k);
            end
        end
    end

    logic            complete_q, complete_d;
    logic            valid_q, valid_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [VW-1:0]   val_q, val_d;
    logic [TW-1:0]   tag_q, tag_d;
    logic [EW-1:0]   head_sel;

    assign head_sel = head[gnt_idx];

    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        complete_d = gnt_valid & ~flush;
        valid_d    = complete_d & head_sel[TW];
        addr_d     = addr_q;
        val_d      = val_q;
        tag_d      = tag_q;
        if (flush) begin
            rr_ptr_d = '0;
        end else if (gnt_valid) begin
            rr_ptr_d = (gnt_idx == IW'(NUM_FU - 1)) ? '0 : gnt_idx + IW'(1);
        end
        if (complete_d) begin
            addr_d = head_sel[EW-1 -: AW];
            val_d  = head_sel[TW+VW -: VW];
            tag_d  = head_sel[TW-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr_q   <= '0;
            complete_q <= 1'b0;
            valid_q    <= 1'b0;
            addr_q     <= '0;
            val_q      <= '0;
            tag_q      <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            complete_q <= complete_d;
            valid_q    <= valid_d;
            addr_q     <= addr_d;
            val_q      <= val_d;
            tag_q      <= tag_d;
        end
    end

    assign CDB_if.valid         = valid_q;
    assign CDB_if.register_addr = addr_q;
    assign CDB_if.register_val  = val_q;
    assign cdb_complete         = complete_q;
    assign cdb_inst_tag         = tag_q;
endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Master end of the common data bus. Collects completed results from the execution units, holds them in small per-unit queues, and picks one per cycle with round-robin priority. The chosen result drives `CDB_if` through a register. The physical register file and the reservation stations act as CDB slaves. The ROB receives a separate completion strobe and tag.

## Interface

Parameters:
- `NUM_FU`, 3: number of execution units. Index 0 is the ALU, 1 is memory, 2 is branch.
- `FIFO_DEPTH`, 2: entries per unit queue. Must be a power of 2 and at least 2.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-low reset.
- `flush`  in  1  pipeline flush. Discards all queued and in-flight results.
- `fu_valid`  in  `NUM_FU`  per-unit result valid.
- `fu_ready`  out  `NUM_FU`  per-unit queue can accept a result.
- `fu_reg_addr`  in  `NUM_FU`×`PHYSICAL_REG_NUM_WIDTH`  destination physical register.
- `fu_reg_val`  in  `NUM_FU`×`REG_VAL_WIDTH`  result value.
- `fu_reg_wb`  in  `NUM_FU`  result writes a register.
- `fu_inst_tag`  in  `NUM_FU`×`ROB_SIZE_WIDTH`  ROB tag.
- `CDB_if`  `CDB_IF.master`  drives `valid`, `register_addr` and `register_val`.
- `cdb_complete`  out  1  completion strobe to the ROB.
- `cdb_inst_tag`  out  `ROB_SIZE_WIDTH`  tag of the completing instruction.

## Operation

Queues:
- Each unit has one FIFO holding {addr, val, wb, tag}. It has a write pointer, a read pointer and a `$clog2(FIFO_DEPTH)+1`-bit count.
- Push when `fu_valid[i] & fu_ready[i]`.
- `fu_ready[i] = (count_i != FIFO_DEPTH)`. It is a function of registered count only, with no combinational path from a same-cycle pop.
- Pointers wrap modulo `FIFO_DEPTH`.
- A push and a pop in the same cycle leave the count unchanged.
- With `fu_valid` high while `fu_ready` is low, the arbiter ignores the result. The unit must hold it.

Arbitration:
- Request vector `req[i] = (count_i != 0)`.
- Round-robin pointer `rr_ptr`, reset to 0.
- The grant goes to the first requesting unit at or after `rr_ptr`, searching with wrap.
- On a grant to unit g, `rr_ptr` becomes (g+1) mod `NUM_FU` and queue g pops.
- With no request: no grant, and `rr_ptr` holds.
- Exactly one result leaves per cycle, at most.

Output register:
- Loaded every cycle from the granted head entry.
- `cdb_complete` = grant present.
- `CDB_if.valid` = grant present & wb.
- `register_addr`, `register_val` and `cdb_inst_tag` take the entry fields.
- With no grant, `cdb_complete` and `valid` go to 0. The data fields hold their previous values.
- Results with wb=0 (stores, branches) complete to the ROB but never write the register file.

Flush:
- When `flush` is high, all counts and pointers clear at the next edge.
- Pushes in the flush cycle are discarded.
- `cdb_complete` and `CDB_if.valid` register 0 at the next edge.
- `rr_ptr` resets to 0.

Reset:
- Asserting `reset` clears the queues, `rr_ptr` and all outputs to 0 asynchronously, at any time including mid-operation.
- `fu_ready` is all-ones while `reset` is asserted and after release.

## Timing

- Latency: a result pushed at edge N, into an empty system, appears on `CDB_if` after edge N+1. That is one cycle of queueing plus the registered output.
- Throughput: one broadcast per cycle, sustained.
- Slaves sample `CDB_if` on the edge after it goes valid. The slave register file writes at that edge.
- Bound on waiting: a queued head entry is broadcast within `NUM_FU` cycles once it becomes head.
- A full queue deasserts `fu_ready` in the cycle after the filling push. It reasserts in the cycle after the first pop.
- No combinational path from any input to any output. `fu_ready` depends on counts only.

## Test plan

1. Single result:
   - Stimulus: unit 0 pushes addr=5, val=0x1234, wb=1, tag=3 at edge 1.
   - Required: after edge 2, `valid=1`, `register_addr=5`, `register_val=0x1234`, `cdb_complete=1`, `cdb_inst_tag=3`.
   - Required: after edge 3, `valid=0` and `cdb_complete=0`.
2. Simultaneous push:
   - Stimulus: all three units push one result each at edge 1.
   - Required: broadcasts appear in unit order 0, 1, 2 on consecutive cycles, with `rr_ptr` wrapping to 0.
   - Required: no gaps and no duplicates.
3. Fairness:
   - Stimulus: units 0 and 1 push continuously.
   - Required: grants alternate 0, 1, 0, 1.
   - Required: unit 0 never wins twice in a row while unit 1 is requesting.
4. Backpressure:
   - Stimulus: unit 2 pushes 3 results back-to-back while unit 0 keeps winning, with `FIFO_DEPTH=2`.
   - Required: `fu_ready[2]` drops after the second push.
   - Required: the third result is held by the unit and accepted later, and all 3 broadcast in order.
5. Non-writing result:
   - Stimulus: unit 1 pushes wb=0, tag=7.
   - Required: `cdb_complete=1`, `cdb_inst_tag=7`, `CDB_if.valid=0`.
6. Flush and reset:
   - Stimulus: flush with 2 entries queued in each unit, plus a push in the same cycle.
   - Required: nothing is broadcast afterwards, `fu_ready` returns to all-ones, and `rr_ptr` returns to 0.
   - Stimulus: pull `reset` low asynchronously mid-broadcast.
   - Required: outputs go to 0 immediately, without waiting for a clock edge.
